// File: rtl/mem_pkg.sv
// Shared constants and the fault-classification helper for the MEM-stage data memory.
// Everything here is pure combinational.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FLT_OK    = 2'b00;
    localparam logic [1:0] FLT_MISAL = 2'b01;
    localparam logic [1:0] FLT_OOR   = 2'b10;
    localparam logic [1:0] FLT_ILL   = 2'b11;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Priority is illegal > misaligned > out-of-range.
    function automatic logic [1:0] fault_code(input logic       we,
                                              input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic       oor);
        logic ill;
        logic mis;
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
              (we && ((f3 == F3_BU) || (f3 == F3_HU)));
        mis = (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
              ((f3 == F3_W) && (off != 2'b00));
        if (ill)      return FLT_ILL;
        else if (mis) return FLT_MISAL;
        else if (oor) return FLT_OOR;
        else          return FLT_OK;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes and replicated write data, and load
// extraction with sign/zero extension from the addressed word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wlanes,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shift;

    assign w_shift = i_rword >> {i_off, 3'b000};

    always_comb begin
        o_be     = 4'b0000;
        o_wlanes = 32'd0;
        case (i_funct3)
            F3_B: begin
                o_be     = 4'b0001 << i_off;
                o_wlanes = {4{i_wdata[7:0]}};
            end
            F3_H: begin
                o_be     = i_off[1] ? 4'b1100 : 4'b0011;
                o_wlanes = {2{i_wdata[15:0]}};
            end
            F3_W: begin
                o_be     = 4'b1111;
                o_wlanes = i_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_rdata = 32'd0;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_BU:   o_rdata = {24'd0, w_shift[7:0]};
            F3_H:    o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_HU:   o_rdata = {16'd0, w_shift[15:0]};
            F3_W:    o_rdata = w_shift;
            default: o_rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory with B/H/W access, fault reporting and a
// configurable load latency behind a valid/ready request/response handshake.
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_fault
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      r_mem [DEPTH_WORDS];
    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_nxt;
    logic             r_ready;
    logic             w_ready_nxt;
    logic             w_done;
    logic             w_accept;
    logic             w_oor;
    logic             w_wr;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_fault;
    logic [3:0]       w_be;
    logic [31:0]      w_wlanes;
    logic [31:0]      w_rdata;
    logic [31:0]      w_ld_data;
    logic [31:0]      r_pdata;
    logic [1:0]       r_pfault;
    logic             r_resp_valid;
    logic [31:0]      r_resp_rdata;
    logic [1:0]       r_resp_fault;

    assign w_accept = req_valid & r_ready;
    assign w_idx    = req_addr[IDX_W+1:2];

    generate
        if (ADDR_W > IDX_W + 2) begin : g_oor
            assign w_oor = |req_addr[ADDR_W-1:IDX_W+2];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_fault   = fault_code(req_we, req_funct3, req_addr[1:0], w_oor);
    assign w_wr      = w_accept & req_we & (w_fault == FLT_OK);
    assign w_ld_data = (w_fault == FLT_OK) ? w_rdata : 32'd0;

    mem_lane_align u_align (
        .i_funct3 (req_funct3),
        .i_off    (req_addr[1:0]),
        .i_wdata  (req_wdata),
        .i_rword  (r_mem[w_idx]),
        .o_be     (w_be),
        .o_wlanes (w_wlanes),
        .o_rdata  (w_rdata)
    );

    // Array is deliberately left out of reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && !req_we && (READ_LATENCY > 1)) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = 3'(READ_LATENCY - 1);
                end
            end
            BUSY: begin
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 3'd0;
                    w_done      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Ready is registered, so it rises together with the final response pulse.
        w_ready_nxt = (w_state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pdata      <= 32'd0;
            r_pfault     <= FLT_OK;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_fault <= FLT_OK;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_fault <= FLT_OK;
            if (w_done) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= r_pdata;
                r_resp_fault <= r_pfault;
            end else if (w_accept && (req_we || (READ_LATENCY == 1))) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= req_we ? 32'd0 : w_ld_data;
                r_resp_fault <= w_fault;
            end
            if (w_accept && !req_we) begin
                r_pdata  <= w_ld_data;
                r_pfault <= w_fault;
            end
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_fault = r_resp_fault;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomized bench for data_memory_ctrl: three instances (latency 1, 3, 4)
// checked against a byte-array reference model with an expected-response queue.
module tb_data_memory_ctrl;

    localparam int DEPTH = 64;
    localparam int NI    = 3;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic [1:0]  fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst        [NI];
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_we     [NI];
    logic [2:0]  req_funct3 [NI];
    logic [31:0] req_addr   [NI];
    logic [31:0] req_wdata  [NI];
    logic        resp_valid [NI];
    logic [31:0] resp_rdata [NI];
    logic [1:0]  resp_fault [NI];

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   act        = 0;
    int   free_c [NI];
    exp_t q[$];
    exp_t mon_e;
    logic [7:0] mm [NI][0:4*DEPTH-1];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            data_memory_ctrl #(
                .DEPTH_WORDS  (DEPTH),
                .READ_LATENCY ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
                .ADDR_W       (32)
            ) u_dut (
                .clk        (clk),
                .rst        (rst[g]),
                .req_valid  (req_valid[g]),
                .req_ready  (req_ready[g]),
                .req_we     (req_we[g]),
                .req_funct3 (req_funct3[g]),
                .req_addr   (req_addr[g]),
                .req_wdata  (req_wdata[g]),
                .resp_valid (resp_valid[g]),
                .resp_rdata (resp_rdata[g]),
                .resp_fault (resp_fault[g])
            );
        end
    endgenerate

    function automatic int rl_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: byte-array memory, rules applied directly to size/alignment/range.
    task automatic model(input int k, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [1:0] flt, output logic [31:0] rd);
        int          n;
        logic        ill, mis, oor;
        logic [31:0] v;
        n   = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        ill = (f3 == 3'd3) || (f3 >= 3'd6) || (we && (f3 >= 3'd4));
        mis = (addr % n) != 0;
        oor = addr >= 32'(4 * DEPTH);
        flt = ill ? 2'd3 : (mis ? 2'd1 : (oor ? 2'd2 : 2'd0));
        rd  = 32'd0;
        if (flt == 2'd0) begin
            if (we) begin
                for (int i = 0; i < n; i++) mm[k][addr + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(mm[k][addr + i]) << (8 * i));
                if (!f3[2] && (n < 4) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                rd = v;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (k != act) begin
                if (resp_valid[k]) chk("idle_inst_resp", 32'(resp_valid[k]), 32'd0);
            end else begin
                if (q.size() > 0 && q[0].due < cyc) begin
                    chk("resp_timeout", 32'(cyc), 32'(q[0].due));
                    void'(q.pop_front());
                end
                if (resp_valid[k]) begin
                    if (q.size() == 0) begin
                        chk("spurious_resp", 32'd1, 32'd0);
                    end else begin
                        mon_e = q.pop_front();
                        chk("resp_cycle", 32'(cyc), 32'(mon_e.due));
                        chk("resp_rdata", resp_rdata[k], mon_e.rdata);
                        chk("resp_fault", 32'(resp_fault[k]), 32'(mon_e.fault));
                    end
                end else begin
                    chk("quiet_rdata", resp_rdata[k], 32'd0);
                    chk("quiet_fault", 32'(resp_fault[k]), 32'd0);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int k, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        logic [1:0]  flt;
        logic [31:0] rd;
        exp_t        e;
        int          w;
        bit          got;
        req_valid[k]  = 1'b1;
        req_we[k]     = we;
        req_funct3[k] = f3;
        req_addr[k]   = addr;
        req_wdata[k]  = wd;
        w   = 0;
        got = 1'b0;
        while (!got && w <= 8) begin
            @(negedge clk);
            chk("req_ready", 32'(req_ready[k]), 32'(cyc >= free_c[k]));
            if (req_ready[k]) got = 1'b1;
            else w++;
        end
        if (!got) begin
            chk("accept_timeout", 32'(w), 32'd0);
            req_valid[k] = 1'b0;
        end else begin
            model(k, we, f3, addr, wd, flt, rd);
            e.due   = cyc + (we ? 1 : rl_of(k));
            e.rdata = rd;
            e.fault = flt;
            q.push_back(e);
            free_c[k] = (!we && rl_of(k) > 1) ? cyc + rl_of(k) : cyc + 1;
            @(posedge clk);
            #1;
            req_valid[k] = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() > 0 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (q.size() > 0) chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic rand_op(input int k);
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          r;
        we = 1'($urandom);
        r  = $urandom_range(0, 9);
        f3 = (r == 0) ? 3'($urandom) : (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
        if (f3 == 3'd3 && r != 0) f3 = 3'd2;
        r = $urandom_range(0, 9);
        if (r == 0)      addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 1023));
        else if (r == 1) addr = $urandom | 32'h8000_0000;
        else             addr = 32'($urandom_range(0, 4 * DEPTH - 1));
        if (r >= 4) addr = addr & ~32'((1 << f3[1:0]) - 1);
        issue(k, we, f3, addr, $urandom);
        if ($urandom_range(0, 3) == 0) idle(1);
    endtask

    task automatic init_mem(input int k);
        for (int a = 0; a < DEPTH; a++) issue(k, 1'b1, 3'b010, 32'(4 * a), $urandom);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k]        = 1'b1;
            req_valid[k]  = 1'b1;
            req_we[k]     = 1'b1;
            req_funct3[k] = 3'b010;
            req_addr[k]   = 32'h0;
            req_wdata[k]  = 32'hDEAD_BEEF;
            free_c[k]     = 0;
        end
        #2;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk("rst_ready", 32'(req_ready[k]), 32'd0);
                chk("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 1'b0;
            rst[k]       = 1'b1;
            free_c[k]    = cyc + 1;
        end
        idle(2);

        // Latency 1: directed store/load, byte lanes, faults.
        act = 0;
        init_mem(0);
        issue(0, 1'b1, 3'b010, 32'h10, 32'h8000_00FF);
        issue(0, 1'b0, 3'b000, 32'h10, 32'h0);
        issue(0, 1'b0, 3'b100, 32'h13, 32'h0);
        issue(0, 1'b1, 3'b010, 32'h20, 32'h1122_3344);
        issue(0, 1'b1, 3'b001, 32'h22, 32'h0000_BEEF);
        issue(0, 1'b0, 3'b010, 32'h20, 32'h0);
        issue(0, 1'b0, 3'b001, 32'h22, 32'h0);
        issue(0, 1'b0, 3'b010, 32'h21, 32'h0);
        issue(0, 1'b1, 3'b001, 32'h23, 32'h1234_5678);
        issue(0, 1'b0, 3'b010, 32'h20, 32'h0);
        issue(0, 1'b0, 3'b010, 32'(4 * DEPTH), 32'h0);
        issue(0, 1'b0, 3'b011, 32'h20, 32'h0);
        issue(0, 1'b1, 3'b101, 32'h20, 32'h5555_5555);
        issue(0, 1'b0, 3'b010, 32'h20, 32'h0);
        repeat (150) rand_op(0);
        drain();

        // Store attempt held during reset must not reach memory.
        req_we[0] = 1'b1; req_funct3[0] = 3'b010;
        req_addr[0] = 32'h10; req_wdata[0] = 32'h0BAD_F00D;
        req_valid[0] = 1'b1;
        rst[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_ready", 32'(req_ready[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rst[0]       = 1'b1;
        free_c[0]    = cyc + 1;
        idle(2);
        issue(0, 1'b0, 3'b010, 32'h10, 32'h0);
        drain();

        // Latency 3: back-to-back loads stall, then random mix.
        act = 1;
        init_mem(1);
        issue(1, 1'b0, 3'b010, 32'h40, 32'h0);
        issue(1, 1'b0, 3'b000, 32'h41, 32'h0);
        repeat (100) rand_op(1);
        drain();

        // Latency 4: reset two cycles after a load accept drops its response.
        act = 2;
        init_mem(2);
        issue(2, 1'b0, 3'b010, 32'h40, 32'h0);
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midop_rst_ready", 32'(req_ready[2]), 32'd0);
        @(posedge clk);
        #1;
        rst[2]    = 1'b1;
        free_c[2] = cyc + 1;
        idle(8);
        issue(2, 1'b0, 3'b010, 32'h40, 32'h0);
        repeat (60) rand_op(2);
        drain();

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (compared=%0d)", compared);
        $fatal(1, "watchdog");
    end

endmodule
